// File: rtl/shift_seq_pkg.sv
// ============================================================================
// Module   : shift_seq_pkg
// Brief    : Shared encodings for the rotate sequencer and its checker.
//            Optional checker build macro: SHIFT_SEQ_CHECK_EN
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package shift_seq_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ROR  = 2'b01;
  localparam logic [1:0] OP_ROL  = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Reserved opcode behaves exactly like pass.
  function automatic logic is_pass(input logic [1:0] op);
    return (op == OP_PASS) || (op == OP_RSV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_seq_chk.sv
// ============================================================================
// Module   : shift_seq_chk
// Brief    : Reference rotator and sticky comparator against the external
//            shifter; built only when SHIFT_SEQ_CHECK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_seq_chk
  import shift_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              fbus,
  input  logic              frbus,
  input  logic              flbus,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] sh_w,
  input  logic              sh_cf,
  output logic              err
);

  logic [DATA_W-1:0] w_exp_w;
  logic              w_exp_cf;
  logic              w_onehot_bad;
  logic              w_mismatch;
  logic              r_err;

  always_comb begin
    w_exp_w  = acc;
    w_exp_cf = 1'b0;
    if (frbus) begin
      w_exp_w  = {acc[0], acc[DATA_W-1:1]};
      w_exp_cf = acc[0];
    end else if (flbus) begin
      w_exp_w  = {acc[DATA_W-2:0], acc[DATA_W-1]};
      w_exp_cf = acc[DATA_W-1];
    end
  end

  assign w_onehot_bad = (fbus & frbus) | (fbus & flbus) | (frbus & flbus);
  assign w_mismatch   = run && ((sh_w != w_exp_w) || (sh_cf != w_exp_cf));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_mismatch || w_onehot_bad) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;

endmodule

`default_nettype wire

// File: rtl/shift_seq.sv
// ============================================================================
// Module   : shift_seq
// Brief    : Multi-cycle rotate sequencer driving a single-step bus shifter.
//            Define SHIFT_SEQ_CHECK_EN to build the shifter result checker.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_seq
  import shift_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [2:0]        count,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout,
  output logic              cf_out,
  output logic              err,
  output logic              fbus,
  output logic              frbus,
  output logic              flbus,
  output logic [DATA_W-1:0] sh_a,
  input  logic [DATA_W-1:0] sh_w,
  input  logic              sh_cf
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_dout;
  logic [2:0]        r_cnt;
  logic [1:0]        r_op;
  logic              r_cf;
  logic              r_cf_out;
  logic              w_pass_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt <= 3'd1) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Count 0 and pass-class ops both resolve to a single fbus step.
  assign w_pass_sel = (r_cnt == 3'd0) || is_pass(r_op);

  always_comb begin
    busy  = (r_state != S_IDLE);
    done  = (r_state == S_DONE);
    fbus  = 1'b0;
    frbus = 1'b0;
    flbus = 1'b0;
    if (r_state == S_RUN) begin
      if (w_pass_sel)            fbus  = 1'b1;
      else if (r_op == OP_ROR)   frbus = 1'b1;
      else if (r_op == OP_ROL)   flbus = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_cnt    <= 3'd0;
      r_op     <= OP_PASS;
      r_cf     <= 1'b0;
      r_dout   <= '0;
      r_cf_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= din;
            r_cnt <= is_pass(op) ? 3'd0 : count;
            r_op  <= op;
          end
        end
        S_RUN: begin
          r_acc <= sh_w;
          r_cf  <= sh_cf;
          if (r_cnt > 3'd1) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            // Final step: publish the value being captured into acc.
            r_dout   <= sh_w;
            r_cf_out <= sh_cf;
          end
        end
        default: ;
      endcase
    end
  end

  assign sh_a   = r_acc;
  assign dout   = r_dout;
  assign cf_out = r_cf_out;

`ifdef SHIFT_SEQ_CHECK_EN
  shift_seq_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (r_state == S_RUN),
    .fbus  (fbus),
    .frbus (frbus),
    .flbus (flbus),
    .acc   (r_acc),
    .sh_w  (sh_w),
    .sh_cf (sh_cf),
    .err   (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_seq.sv
// ============================================================================
// Module   : tb_shift_seq
// Brief    : Scoreboard bench for shift_seq with a behavioural shifter and
//            reference rotate model. Honours SHIFT_SEQ_CHECK_EN for err.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shift_seq;
  import shift_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [2:0] count = 3'd0;
  logic [7:0] din = 8'h00;
  logic       busy, done, cf_out, err, fbus, frbus, flbus;
  logic [7:0] dout, sh_a, sh_w;
  logic       sh_cf;
  logic       inject = 1'b0;

  shift_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .count(count), .din(din),
    .busy(busy), .done(done), .dout(dout), .cf_out(cf_out), .err(err),
    .fbus(fbus), .frbus(frbus), .flbus(flbus),
    .sh_a(sh_a), .sh_w(sh_w), .sh_cf(sh_cf)
  );

  always #5 clk = ~clk;

  // Behavioural single-step shifter; inject corrupts bit 0 of a right step.
  always_comb begin
    sh_w  = sh_a;
    sh_cf = 1'b0;
    if (frbus) begin
      sh_w  = (sh_a >> 1) | (sh_a << 7);
      sh_cf = sh_a[0];
    end else if (flbus) begin
      sh_w  = (sh_a << 1) | (sh_a >> 7);
      sh_cf = sh_a[7];
    end
    if (inject && frbus) sh_w[0] = ~sh_w[0];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       c;
    int         c0;
    int         cd;
    int         nf;
    int         nr;
    int         nl;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   nf = 0, nr = 0, nl = 0;
  logic [7:0] held_d = 8'h00;
  logic       held_c = 1'b0;
  logic       exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rotate-by-n result {carry, value}; fault flips bit 0 after the first step.
  function automatic logic [8:0] ref_op(input logic [1:0] o, input logic [7:0] d,
                                        input int n, input bit fault);
    logic [7:0] v = d;
    logic       c = 1'b0;
    if (o == 2'b00 || o == 2'b11 || n == 0) return {1'b0, d};
    for (int i = 0; i < n; i++) begin
      if (o == 2'b01) begin
        c = v[0];
        v = (v >> 1) | (v << 7);
        if (fault && i == 0) v = v ^ 8'h01;
      end else begin
        c = v[7];
        v = (v << 1) | (v >> 7);
      end
    end
    return {c, v};
  endfunction

  task automatic wait_idle();
    int w = 0;
    while (busy === 1'b1 && w < 40) begin
      @(negedge clk); #1;
      w++;
    end
    if (w >= 40) check("idle_timeout", 1, 0);
  endtask

  task automatic launch(input logic [1:0] o, input logic [7:0] d, input logic [2:0] n,
                        input bit mid_start, input bit fault);
    exp_t e;
    logic [8:0] r;
    bit   p;
    int   len;
    wait_idle();
    p   = (o == 2'b00 || o == 2'b11 || n == 3'd0);
    len = p ? 1 : int'(n);
    r   = ref_op(o, d, int'(n), fault);
    e.d = r[7:0];
    e.c = r[8];
    e.c0 = cyc + 1;
    e.cd = cyc + 1 + len;
    e.nf = p ? 1 : 0;
    e.nr = (!p && o == 2'b01) ? int'(n) : 0;
    e.nl = (!p && o == 2'b10) ? int'(n) : 0;
    sbq.push_back(e);
    start = 1'b1; op = o; din = d; count = n; inject = fault;
    @(negedge clk); #1;
    start = mid_start;
    op    = 2'($urandom_range(0, 3));
    din   = 8'($urandom_range(0, 255));
    count = 3'($urandom_range(0, 7));
    @(negedge clk); #1;
    start  = 1'b0;
    inject = 1'b0;
  endtask

  // Monitor/scoreboard: all periodic checks happen on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      exp_t e;
      logic exp_busy;
      exp_busy = (sbq.size() > 0) && (cyc >= sbq[0].c0) && (cyc <= sbq[0].cd);
      check("busy", busy, exp_busy);
      check("sel_onehot", {fbus, frbus, flbus} inside {3'b000, 3'b001, 3'b010, 3'b100}, 1);
      check("err", err, exp_err);
`ifdef SHIFT_SEQ_CHECK_EN
      if (frbus && inject) exp_err = 1'b1;
`endif
      nf += int'(fbus);
      nr += int'(frbus);
      nl += int'(flbus);
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("done_cycle", cyc, e.cd);
          check("dout", dout, e.d);
          check("cf_out", cf_out, e.c);
          check("fbus_cycles", nf, e.nf);
          check("frbus_cycles", nr, e.nr);
          check("flbus_cycles", nl, e.nl);
          held_d = e.d;
          held_c = e.c;
        end
        nf = 0; nr = 0; nl = 0;
      end else if (sbq.size() > 0 && cyc > sbq[0].cd) begin
        check("done_timeout", 1, 0);
        void'(sbq.pop_front());
        nf = 0; nr = 0; nl = 0;
      end
      check("dout_hold", dout, held_d);
      check("cf_hold", cf_out, held_c);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_cf"}, cf_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sel"}, {fbus, frbus, flbus}, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_sh_a"}, sh_a, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk); #1;

    launch(OP_ROL, 8'h81, 3'd1, 1'b0, 1'b0);
    launch(OP_ROR, 8'h01, 3'd3, 1'b0, 1'b0);
    launch(OP_PASS, 8'hA5, 3'd5, 1'b0, 1'b0);
    launch(OP_ROL, 8'h3C, 3'd0, 1'b0, 1'b0);
    launch(OP_ROL, 8'h01, 3'd7, 1'b1, 1'b0);
    launch(OP_RSV, 8'h5A, 3'd4, 1'b1, 1'b0);

    repeat (25) begin
      launch(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); #1;
      end
    end

    launch(OP_ROR, 8'hB6, 3'd2, 1'b0, 1'b1);
    launch(OP_ROL, 8'h42, 3'd3, 1'b0, 1'b0);
    launch(OP_PASS, 8'h99, 3'd0, 1'b0, 1'b0);

    // Reset in the third RUN cycle of a long rotate.
    wait_idle();
    begin
      exp_t e;
      e.d = 8'h00; e.c = 1'b0; e.c0 = cyc + 1; e.cd = cyc + 7;
      e.nf = 0; e.nr = 6; e.nl = 0;
      sbq.push_back(e);
    end
    start = 1'b1; op = OP_ROR; din = 8'hF0; count = 3'd6;
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    sbq.delete();
    nf = 0; nr = 0; nl = 0;
    held_d = 8'h00; held_c = 1'b0; exp_err = 1'b0;
    @(negedge clk); #1;
    check_all_zero("midrun_reset");
    rst_n = 1'b1;
    @(negedge clk); #1;
    launch(OP_ROR, 8'hF0, 3'd6, 1'b0, 1'b0);

    begin
      int w = 0;
      while (sbq.size() > 0 && w < 30) begin
        @(negedge clk); #1;
        w++;
      end
    end
    check("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
